// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and types for the VGA tile renderer
//
// Contents:
//   H_ACTIVE, V_ACTIVE        visible screen size in pixels
//   RGB_R, RGB_G, RGB_B       bit positions inside an {R,G,B} triplet
//   DEF_TILE_SHIFT            default log2 of the tile edge in screen pixels
//   DEF_GLYPH_SHIFT           default log2 of the glyph edge in glyph pixels
//   color_sel_e               source chosen for an output pixel
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam int RGB_R = 2;
    localparam int RGB_G = 1;
    localparam int RGB_B = 0;

    localparam int DEF_TILE_SHIFT  = 5;
    localparam int DEF_GLYPH_SHIFT = 4;

    typedef enum logic [1:0] {
        SEL_BLANK,
        SEL_TEST,
        SEL_BG,
        SEL_GLYPH
    } color_sel_e;

endpackage

// File: rtl/vga_blink_timer.sv
// rtl/vga_blink_timer.sv - frame-start detect, blink phase generator and render-mode latch
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   pix_en           pixel enable; a frame start only counts on an enabled step
//   active, col, row timing-generator pixel; frame start is the first visible pixel (0,0)
//   mode             live render-mode input, captured only at frame start
//   mode_latched     render mode in force for the current frame
//   blink_phase      toggles every BLINK_FRAMES frame starts
module vga_blink_timer
    import vga_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic       active,
    input  logic [9:0] col,
    input  logic [8:0] row,
    input  logic       mode,
    output logic       mode_latched,
    output logic       blink_phase
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             phase_q, phase_d;
    logic             mode_q, mode_d;
    logic             frame_start;

    always_comb begin
        frame_start = pix_en && active && (col == '0) && (row == '0);
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        mode_d      = mode_q;
        if (frame_start) begin
            mode_d = mode;
            if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            mode_q      <= mode_d;
        end
    end

    assign mode_latched = mode_q;
    assign blink_phase  = phase_q;

endmodule

// File: rtl/vga_tile_renderer.sv
// rtl/vga_tile_renderer.sv - three-stage tile/glyph renderer from VGA timing to RGB/sync pins
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   pix_en              pixel enable; every pipeline register advances only when high
//   active, col, row    timing-generator visibility and pixel position
//   hsync_in, vsync_in  timing-generator syncs, delayed to line up with R/G/B
//   mode, test_rgb      frame-latched render mode (0 = fill with test_rgb)
//   bg_rgb              colour outside the map and for blinked-off tiles
//   map_addr/rd_en/data tile-map RAM port; data {blink, glyph_idx} one clk after read
//   glyph_addr/rd_en/data glyph RAM port; address {glyph_idx, glyph_row}, data row of triplets
//   R, G, B             registered colour, 3 pix_en steps after the input sample
//   hSync, vSync        registered syncs aligned with R/G/B
//   blink_phase         current blink half-period
module vga_tile_renderer
    import vga_pkg::*;
#(
    parameter int   TILE_SHIFT   = DEF_TILE_SHIFT,
    parameter int   GLYPH_SHIFT  = DEF_GLYPH_SHIFT,
    parameter int   MAP_COLS     = H_ACTIVE >> DEF_TILE_SHIFT,
    parameter int   MAP_ROWS     = V_ACTIVE >> DEF_TILE_SHIFT,
    parameter int   MAP_AW       = 9,
    parameter int   IDX_W        = 6,
    parameter int   BLINK_FRAMES = 30,
    parameter logic SYNC_IDLE    = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pix_en,
    input  logic                          active,
    input  logic [9:0]                    col,
    input  logic [8:0]                    row,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic                          mode,
    input  logic [2:0]                    test_rgb,
    input  logic [2:0]                    bg_rgb,
    output logic [MAP_AW-1:0]             map_addr,
    output logic                          map_rd_en,
    input  logic [IDX_W:0]                map_data,
    output logic [IDX_W+GLYPH_SHIFT-1:0]  glyph_addr,
    output logic                          glyph_rd_en,
    input  logic [(3<<GLYPH_SHIFT)-1:0]   glyph_data,
    output logic                          R,
    output logic                          G,
    output logic                          B,
    output logic                          hSync,
    output logic                          vSync,
    output logic                          blink_phase
);

    localparam int GLYPH_PIX = 1 << GLYPH_SHIFT;
    localparam int GLYPH_W   = 3 * GLYPH_PIX;
    localparam int TX_W      = 10 - TILE_SHIFT;
    localparam int TY_W      = 9 - TILE_SHIFT;

    typedef struct packed {
        logic                   active;
        logic                   in_map;
        logic [GLYPH_SHIFT-1:0] gx;
        logic [GLYPH_SHIFT-1:0] gy;
        logic                   hs;
        logic                   vs;
    } stage1_t;

    typedef struct packed {
        logic                   active;
        logic                   in_map;
        logic                   blink;
        logic [GLYPH_SHIFT-1:0] gx;
        logic                   hs;
        logic                   vs;
    } stage2_t;

    localparam stage1_t S1_RST = '{active: 1'b0, in_map: 1'b0, gx: '0, gy: '0,
                                   hs: SYNC_IDLE, vs: SYNC_IDLE};
    localparam stage2_t S2_RST = '{active: 1'b0, in_map: 1'b0, blink: 1'b0, gx: '0,
                                   hs: SYNC_IDLE, vs: SYNC_IDLE};

    logic [TX_W-1:0]        tile_x;
    logic [TY_W-1:0]        tile_y;
    logic [GLYPH_SHIFT-1:0] gx;
    logic [GLYPH_SHIFT-1:0] gy;
    logic                   in_map;

    stage1_t    s1_q, s1_d;
    stage2_t    s2_q, s2_d;
    logic [2:0] rgb_q, rgb_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;

    logic       mode_latched;
    logic [2:0] glyph_rgb;
    logic [2:0] pixel_rgb;
    color_sel_e sel;

    // Tile coordinates use the whole position; the glyph pixel is the upper
    // GLYPH_SHIFT bits of the in-tile offset, so each glyph pixel covers a
    // 2^(TILE_SHIFT-GLYPH_SHIFT) square of screen pixels.
    assign tile_x = TX_W'(col >> TILE_SHIFT);
    assign tile_y = TY_W'(row >> TILE_SHIFT);
    assign gx     = col[TILE_SHIFT-1 -: GLYPH_SHIFT];
    assign gy     = row[TILE_SHIFT-1 -: GLYPH_SHIFT];
    assign in_map = (32'(tile_x) < MAP_COLS) && (32'(tile_y) < MAP_ROWS);

    assign map_addr    = MAP_AW'(32'(tile_y) * 32'(MAP_COLS) + 32'(tile_x));
    assign map_rd_en   = pix_en;
    assign glyph_addr  = {map_data[IDX_W-1:0], s1_q.gy};
    assign glyph_rd_en = pix_en;

    vga_blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink_timer (
        .clk          (clk),
        .rst_n        (reset),
        .pix_en       (pix_en),
        .active       (active),
        .col          (col),
        .row          (row),
        .mode         (mode),
        .mode_latched (mode_latched),
        .blink_phase  (blink_phase)
    );

    // Stage 3 colour choice; glyph pixel 0 sits in the most significant triplet.
    always_comb begin
        glyph_rgb = '0;
        for (int i = 0; i < GLYPH_PIX; i++) begin
            if (s2_q.gx == GLYPH_SHIFT'(i)) begin
                glyph_rgb = glyph_data[GLYPH_W-1-3*i -: 3];
            end
        end

        if (!s2_q.active) begin
            sel = SEL_BLANK;
        end else if (!mode_latched) begin
            sel = SEL_TEST;
        end else if (!s2_q.in_map) begin
            sel = SEL_BG;
        end else if (s2_q.blink && blink_phase) begin
            sel = SEL_BG;
        end else begin
            sel = SEL_GLYPH;
        end

        unique case (sel)
            SEL_BLANK: pixel_rgb = 3'b000;
            SEL_TEST:  pixel_rgb = test_rgb;
            SEL_BG:    pixel_rgb = bg_rgb;
            SEL_GLYPH: pixel_rgb = glyph_rgb;
            default:   pixel_rgb = 3'b000;
        endcase
    end

    // RAM outputs hold between enabled reads, so stage 2 and 3 may consume
    // them on any later enabled step regardless of how sparse pix_en is.
    always_comb begin
        s1_d  = s1_q;
        s2_d  = s2_q;
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (pix_en) begin
            s1_d  = '{active: active, in_map: in_map, gx: gx, gy: gy,
                      hs: hsync_in, vs: vsync_in};
            s2_d  = '{active: s1_q.active, in_map: s1_q.in_map, blink: map_data[IDX_W],
                      gx: s1_q.gx, hs: s1_q.hs, vs: s1_q.vs};
            rgb_d = pixel_rgb;
            hs_d  = s2_q.hs;
            vs_d  = s2_q.vs;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q  <= S1_RST;
            s2_q  <= S2_RST;
            rgb_q <= 3'b000;
            hs_q  <= SYNC_IDLE;
            vs_q  <= SYNC_IDLE;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign R     = rgb_q[RGB_R];
    assign G     = rgb_q[RGB_G];
    assign B     = rgb_q[RGB_B];
    assign hSync = hs_q;
    assign vSync = vs_q;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// tb/tb_vga_tile_renderer.sv - scoreboard bench for vga_tile_renderer with a pixel-level reference model
module tb_vga_tile_renderer;

    localparam int BLINK = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic        active;
    logic [9:0]  col;
    logic [8:0]  row;
    logic        hsync_in;
    logic        vsync_in;
    logic        mode;
    logic [2:0]  test_rgb;
    logic [2:0]  bg_rgb;
    logic [8:0]  map_addr;
    logic        map_rd_en;
    logic [6:0]  map_data;
    logic [9:0]  glyph_addr;
    logic        glyph_rd_en;
    logic [47:0] glyph_data;
    logic        R, G, B, hSync, vSync, blink_phase;

    always #5 clk = ~clk;

    vga_tile_renderer dut (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .active      (active),
        .col         (col),
        .row         (row),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .mode        (mode),
        .test_rgb    (test_rgb),
        .bg_rgb      (bg_rgb),
        .map_addr    (map_addr),
        .map_rd_en   (map_rd_en),
        .map_data    (map_data),
        .glyph_addr  (glyph_addr),
        .glyph_rd_en (glyph_rd_en),
        .glyph_data  (glyph_data),
        .R           (R),
        .G           (G),
        .B           (B),
        .hSync       (hSync),
        .vSync       (vSync),
        .blink_phase (blink_phase)
    );

    // Synchronous-read RAMs; data holds until the next enabled read.
    logic [6:0]  map_mem   [512];
    logic [47:0] glyph_mem [1024];

    always @(posedge clk) begin
        if (map_rd_en)   map_data   <= map_mem[map_addr];
        if (glyph_rd_en) glyph_data <= glyph_mem[glyph_addr];
    end

    typedef struct packed {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: what the frame-start rules say is in force.
    logic m_mode;
    int   m_cnt;
    logic m_phase;
    logic frame_mode;
    int   pen_mode;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [2:0] model_rgb(input logic a, input int c, input int r);
        int          tx, ty, gx, gy, idx;
        logic [6:0]  e;
        logic [47:0] gr;
        if (!a) return 3'b000;
        if (!m_mode) return test_rgb;
        tx = c / 32;
        ty = r / 32;
        if (tx >= 20 || ty >= 15) return bg_rgb;
        e = map_mem[ty * 20 + tx];
        if (e[6] && m_phase) return bg_rgb;
        idx = int'(e[5:0]);
        gx  = (c % 32) / 2;
        gy  = (r % 32) / 2;
        gr  = glyph_mem[idx * 16 + gy];
        return gr[47 - 3 * gx -: 3];
    endfunction

    // After reset the pipeline holds two empty stages before the first real pixel.
    task automatic model_reset();
        m_mode  = 1'b0;
        m_cnt   = 0;
        m_phase = 1'b0;
        exp_q.delete();
        repeat (2) exp_q.push_back('{rgb: 3'b000, hs: 1'b1, vs: 1'b1});
    endtask

    task automatic idle_clk();
        @(negedge clk);
        pix_en   = 1'b0;
        active   = 1'($urandom);
        col      = 10'($urandom);
        row      = 9'($urandom);
        hsync_in = 1'($urandom);
        vsync_in = 1'($urandom);
        mode     = 1'($urandom);
    endtask

    task automatic step_pixel(input logic a, input logic [9:0] c, input logic [8:0] r);
        logic hs, vs, fs;
        if (pen_mode == 1) idle_clk();
        else if (pen_mode == 2) repeat ($urandom_range(0, 2)) idle_clk();
        @(negedge clk);
        hs = 1'($urandom);
        vs = 1'($urandom);
        fs = a && (c == 10'd0) && (r == 9'd0);
        pix_en   = 1'b1;
        active   = a;
        col      = c;
        row      = r;
        hsync_in = hs;
        vsync_in = vs;
        mode     = fs ? frame_mode : 1'($urandom);
        if (fs) begin
            m_mode = frame_mode;
            if (m_cnt == BLINK - 1) begin
                m_cnt   = 0;
                m_phase = !m_phase;
            end else begin
                m_cnt++;
            end
        end
        exp_q.push_back('{rgb: model_rgb(a, int'(c), int'(r)), hs: hs, vs: vs});
    endtask

    task automatic run_frame(input logic fm, input logic [2:0] trgb, input int npix);
        logic [9:0] c;
        logic [8:0] r;
        frame_mode = fm;
        test_rgb   = trgb;
        step_pixel(1'b1, 10'd0, 9'd0);
        for (int i = 0; i < npix; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                c = 10'($urandom_range(1, 31));
                r = 9'($urandom_range(0, 31));
            end else begin
                c = 10'($urandom_range(1, 1023));
                r = 9'($urandom);
            end
            step_pixel($urandom_range(0, 9) != 0, c, r);
        end
        repeat (3) step_pixel(1'b0, 10'($urandom), 9'($urandom));
    endtask

    // Monitor: one expected entry per enabled step while out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (reset && pix_en) begin
                #1;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard_empty actual=0 required=nonzero t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel_rgb_hs_vs", {29'd0, R, G, B, hSync, vSync},
                          {27'd0, e.rgb, e.hs, e.vs});
                    check("blink_phase", {31'd0, blink_phase}, {31'd0, m_phase});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        pix_en   = 1'b0;
        active   = 1'b0;
        col      = '0;
        row      = '0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        mode     = 1'b0;
        test_rgb = 3'b000;
        bg_rgb   = 3'b010;
        pen_mode = 0;
        frame_mode = 1'b1;

        for (int i = 0; i < 512; i++) map_mem[i] = 7'($urandom);
        for (int i = 0; i < 1024; i++) glyph_mem[i] = {16'($urandom), 32'($urandom)};
        map_mem[0]      = {1'b0, 6'd5};
        glyph_mem[5*16] = 48'hFFF000000000;

        // Reset held with random inputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pix_en   = 1'($urandom);
            active   = 1'($urandom);
            col      = 10'($urandom);
            row      = 9'($urandom);
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
            mode     = 1'($urandom);
            #1;
            check("reset_rgb", {29'd0, R, G, B}, 32'd0);
            check("reset_sync", {30'd0, hSync, vSync}, 32'd3);
            check("reset_blink", {31'd0, blink_phase}, 32'd0);
            check("rd_en_follow", {30'd0, map_rd_en, glyph_rd_en}, {30'd0, pix_en, pix_en});
        end
        @(negedge clk);
        pix_en = 1'b0;
        model_reset();
        reset = 1'b1;

        // Glyph decode on tile 0 and address mapping.
        frame_mode = 1'b1;
        test_rgb   = 3'b101;
        step_pixel(1'b1, 10'd0, 9'd0);
        #1 check("map_addr_origin", {23'd0, map_addr}, 32'd0);
        @(posedge clk);
        #1 check("glyph_addr_origin", {22'd0, glyph_addr}, 32'h050);
        for (int c = 1; c < 32; c++) step_pixel(1'b1, 10'(c), 9'd0);
        step_pixel(1'b1, 10'd32, 9'd32);
        #1 check("map_addr_32_32", {23'd0, map_addr}, 32'd21);
        repeat (3) step_pixel(1'b0, 10'($urandom), 9'($urandom));

        // Blinking tile 0 and random frames across several pix_en patterns.
        map_mem[0] = {1'b1, 6'd5};
        bg_rgb     = 3'b010;
        run_frame(1'b0, 3'b101, 24);
        for (int f = 1; f < 70; f++) begin
            pen_mode = f % 3;
            run_frame(($urandom_range(0, 5) != 0), 3'($urandom), 16);
        end

        // Reset in the middle of a line.
        pen_mode = 0;
        frame_mode = 1'b1;
        step_pixel(1'b1, 10'd0, 9'd0);
        for (int c = 290; c <= 300; c++) step_pixel(1'b1, 10'(c), 9'd50);
        #2;
        reset  = 1'b0;
        pix_en = 1'b0;
        #1;
        check("midline_reset_rgb", {29'd0, R, G, B}, 32'd0);
        check("midline_reset_sync", {30'd0, hSync, vSync}, 32'd3);
        check("midline_reset_blink", {31'd0, blink_phase}, 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int c = 301; c <= 330; c++) step_pixel(1'b1, 10'(c), 9'd50);
        repeat (3) step_pixel(1'b0, 10'($urandom), 9'($urandom));
        pen_mode = 1;
        run_frame(1'b1, 3'($urandom), 20);
        pen_mode = 0;
        run_frame(1'b1, 3'($urandom), 20);

        repeat (2) step_pixel(1'b0, 10'($urandom), 9'($urandom));
        @(negedge clk);
        pix_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
